// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - geometry, command constants, FSM states and command helper for the LCD scan reader
package lcd_pkg;

    localparam int LCD_W           = 128;
    localparam int LCD_H           = 128;
    localparam int PAGES           = 16;
    localparam int BYTES_PER_FRAME = PAGES * (3 + LCD_W);

    localparam logic [7:0] CMD_PAGE   = 8'hB0;
    localparam logic [7:0] CMD_COL_LO = 8'h00;
    localparam logic [7:0] CMD_COL_HI = 8'h10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_FETCH,
        ST_SHIFT,
        ST_NEXT,
        ST_DONE
    } lcd_state_e;

    function automatic logic [7:0] cmd_byte(input logic [1:0] idx, input logic [3:0] page);
        case (idx)
            2'd0:    return CMD_PAGE | {4'b0000, page};
            2'd1:    return CMD_COL_LO;
            default: return CMD_COL_HI;
        endcase
    endfunction

endpackage

// File: rtl/spi_byte_tx.sv
// rtl/spi_byte_tx.sv - write-only SPI mode 0 byte shifter, MSB first, with DC held for the byte
module spi_byte_tx #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] byte_in,
    input  logic       dc_in,
    output logic       lcd_sclk,
    output logic       lcd_mosi,
    output logic       lcd_dc,
    output logic       byte_done
);

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    logic [7:0] shreg_q, shreg_d;
    logic [7:0] cnt_q, cnt_d;
    logic [2:0] bit_q, bit_d;
    logic       active_q, active_d;
    logic       sclk_q, sclk_d;
    logic       mosi_q, mosi_d;
    logic       dc_q, dc_d;
    logic       phase_end;

    assign phase_end = (cnt_q == DIV_LAST);
    assign byte_done = active_q && sclk_q && phase_end && (bit_q == 3'd0);

    always_comb begin
        shreg_d  = shreg_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        active_d = active_q;
        sclk_d   = sclk_q;
        mosi_d   = mosi_q;
        dc_d     = dc_q;
        if (load) begin
            shreg_d  = byte_in;
            dc_d     = dc_in;
            mosi_d   = byte_in[7];
            sclk_d   = 1'b0;
            cnt_d    = 8'd0;
            bit_d    = 3'd7;
            active_d = 1'b1;
        end else if (active_q) begin
            if (phase_end) begin
                cnt_d = 8'd0;
                if (!sclk_q) begin
                    sclk_d = 1'b1;
                end else begin
                    // falling edge: next bit goes out while SCLK is low
                    sclk_d = 1'b0;
                    if (bit_q == 3'd0) begin
                        active_d = 1'b0;
                    end else begin
                        bit_d  = bit_q - 3'd1;
                        mosi_d = shreg_q[bit_q - 3'd1];
                    end
                end
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_q  <= 8'h00;
            cnt_q    <= 8'd0;
            bit_q    <= 3'd0;
            active_q <= 1'b0;
            sclk_q   <= 1'b0;
            mosi_q   <= 1'b0;
            dc_q     <= 1'b0;
        end else begin
            shreg_q  <= shreg_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            active_q <= active_d;
            sclk_q   <= sclk_d;
            mosi_q   <= mosi_d;
            dc_q     <= dc_d;
        end
    end

    assign lcd_sclk = sclk_q;
    assign lcd_mosi = mosi_q;
    assign lcd_dc   = dc_q;

endmodule

// File: rtl/lcd_scan_reader.sv
// rtl/lcd_scan_reader.sv - sweeps the frame buffer into page bytes and streams each frame to the LCD
module lcd_scan_reader #(
    parameter int CLK_DIV = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        auto_refresh,
    output logic        rd_en,
    output logic [13:0] rd_addr,
    input  logic        rd_data,
    output logic        lcd_sclk,
    output logic        lcd_mosi,
    output logic        lcd_cs_n,
    output logic        lcd_dc,
    output logic        busy,
    output logic        frame_done
);

    import lcd_pkg::*;

    localparam logic [6:0] COL_LAST   = 7'(LCD_W - 1);
    localparam logic [3:0] PAGE_LAST  = 4'(PAGES - 1);
    localparam logic [1:0] DATA_PHASE = 2'd3;

    lcd_state_e  state_q, state_d;
    logic [3:0]  page_q, page_d;
    logic [6:0]  col_q, col_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic        fetch_last_q, fetch_last_d;
    logic [1:0]  cmd_idx_q, cmd_idx_d;
    logic [7:0]  pix_q, pix_d;
    logic        auto_arm_q, auto_arm_d;
    logic        rd_en_q, rd_en_d;
    logic [13:0] rd_addr_q, rd_addr_d;
    logic        cs_n_q, cs_n_d;
    logic        busy_q, busy_d;
    logic        frame_done_q, frame_done_d;

    logic        tx_load;
    logic [7:0]  tx_byte;
    logic        tx_dc;
    logic        tx_done;

    always_comb begin
        state_d      = state_q;
        page_d       = page_q;
        col_d        = col_q;
        bit_idx_d    = bit_idx_q;
        fetch_last_d = fetch_last_q;
        cmd_idx_d    = cmd_idx_q;
        pix_d        = pix_q;
        auto_arm_d   = auto_arm_q;
        cs_n_d       = cs_n_q;
        busy_d       = busy_q;
        frame_done_d = 1'b0;
        tx_load      = 1'b0;
        tx_byte      = cmd_byte(cmd_idx_q, page_q);
        tx_dc        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // auto_refresh only re-arms in the cycle right after a finished frame
                if (start || (auto_arm_q && auto_refresh)) begin
                    state_d      = ST_CMD;
                    cs_n_d       = 1'b0;
                    busy_d       = 1'b1;
                    page_d       = 4'd0;
                    col_d        = 7'd0;
                    bit_idx_d    = 3'd0;
                    fetch_last_d = 1'b0;
                    cmd_idx_d    = 2'd0;
                end
                auto_arm_d = 1'b0;
            end
            ST_CMD: begin
                tx_load = 1'b1;
                state_d = ST_SHIFT;
            end
            ST_FETCH: begin
                // read issued in cycle k returns in cycle k+1; bit 7 lands on top
                if ((bit_idx_q != 3'd0) || fetch_last_q) begin
                    pix_d = {rd_data, pix_q[7:1]};
                end
                if (fetch_last_q) begin
                    tx_load      = 1'b1;
                    tx_byte      = {rd_data, pix_q[7:1]};
                    tx_dc        = 1'b1;
                    fetch_last_d = 1'b0;
                    state_d      = ST_SHIFT;
                end else if (bit_idx_q == 3'd7) begin
                    bit_idx_d    = 3'd0;
                    fetch_last_d = 1'b1;
                end else begin
                    bit_idx_d = bit_idx_q + 3'd1;
                end
            end
            ST_SHIFT: begin
                if (tx_done) begin
                    state_d = ST_NEXT;
                end
            end
            ST_NEXT: begin
                if (cmd_idx_q != DATA_PHASE) begin
                    cmd_idx_d = cmd_idx_q + 2'd1;
                    state_d   = (cmd_idx_q == 2'd2) ? ST_FETCH : ST_CMD;
                end else if (col_q != COL_LAST) begin
                    col_d   = col_q + 7'd1;
                    state_d = ST_FETCH;
                end else begin
                    col_d = 7'd0;
                    if (page_q != PAGE_LAST) begin
                        page_d    = page_q + 4'd1;
                        cmd_idx_d = 2'd0;
                        state_d   = ST_CMD;
                    end else begin
                        state_d      = ST_DONE;
                        cs_n_d       = 1'b1;
                        busy_d       = 1'b0;
                        frame_done_d = 1'b1;
                        auto_arm_d   = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        rd_en_d   = (state_d == ST_FETCH) && !fetch_last_d;
        rd_addr_d = rd_en_d ? {page_d, bit_idx_d, col_d} : rd_addr_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            page_q       <= 4'd0;
            col_q        <= 7'd0;
            bit_idx_q    <= 3'd0;
            fetch_last_q <= 1'b0;
            cmd_idx_q    <= 2'd0;
            pix_q        <= 8'h00;
            auto_arm_q   <= 1'b0;
            rd_en_q      <= 1'b0;
            rd_addr_q    <= 14'd0;
            cs_n_q       <= 1'b1;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            page_q       <= page_d;
            col_q        <= col_d;
            bit_idx_q    <= bit_idx_d;
            fetch_last_q <= fetch_last_d;
            cmd_idx_q    <= cmd_idx_d;
            pix_q        <= pix_d;
            auto_arm_q   <= auto_arm_d;
            rd_en_q      <= rd_en_d;
            rd_addr_q    <= rd_addr_d;
            cs_n_q       <= cs_n_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    spi_byte_tx #(
        .CLK_DIV (CLK_DIV)
    ) u_tx (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (tx_load),
        .byte_in   (tx_byte),
        .dc_in     (tx_dc),
        .lcd_sclk  (lcd_sclk),
        .lcd_mosi  (lcd_mosi),
        .lcd_dc    (lcd_dc),
        .byte_done (tx_done)
    );

    assign rd_en      = rd_en_q;
    assign rd_addr    = rd_addr_q;
    assign lcd_cs_n   = cs_n_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_lcd_scan_reader.sv
// tb/tb_lcd_scan_reader.sv - scoreboard bench for lcd_scan_reader at CLK_DIV=1 and CLK_DIV=7
module tb_lcd_scan_reader;

    import lcd_pkg::*;

    localparam int     D      = 1;
    localparam longint GOLDEN = 16 * (3 * (16 * D + 2) + 128 * (16 * D + 10)) + 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, start, auto_refresh, rd_data;
    logic        rd_en, lcd_sclk, lcd_mosi, lcd_cs_n, lcd_dc, busy, frame_done;
    logic [13:0] rd_addr;

    logic        rst7_n, start7, rd_data7;
    logic        rd_en7, sclk7, mosi7, cs7_n, dc7, busy7, frame_done7;
    logic [13:0] rd_addr7;
    assign rd_data7 = 1'b1;

    lcd_scan_reader #(.CLK_DIV(D)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .auto_refresh(auto_refresh),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .lcd_sclk(lcd_sclk), .lcd_mosi(lcd_mosi), .lcd_cs_n(lcd_cs_n), .lcd_dc(lcd_dc),
        .busy(busy), .frame_done(frame_done)
    );

    lcd_scan_reader #(.CLK_DIV(7)) u_dut7 (
        .clk(clk), .rst_n(rst7_n), .start(start7), .auto_refresh(1'b0),
        .rd_en(rd_en7), .rd_addr(rd_addr7), .rd_data(rd_data7),
        .lcd_sclk(sclk7), .lcd_mosi(mosi7), .lcd_cs_n(cs7_n), .lcd_dc(dc7),
        .busy(busy7), .frame_done(frame_done7)
    );

    int     total = 0;
    int     bad   = 0;
    longint cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // pages 0-4 all lit, pages 5-9 odd rows lit, pages 10-15 only bottom row of column 5
    function automatic logic pixel(input logic [13:0] a);
        logic [6:0] row;
        logic [6:0] col;
        row = a[13:7];
        col = a[6:0];
        if (row < 7'd40) return 1'b1;
        if (row < 7'd80) return row[0];
        return (row[2:0] == 3'd7) && (col == 7'd5);
    endfunction

    initial rd_data = 1'b0;
    always @(posedge clk) if (rd_en) rd_data <= pixel(rd_addr);

    function automatic logic [7:0] exp_data(input int p, input int c);
        if (p < 5)  return 8'hFF;
        if (p < 10) return 8'hAA;
        return (c == 5) ? 8'h80 : 8'h00;
    endfunction

    logic [8:0] exp_q[$];

    task automatic push_frame();
        for (int p = 0; p < PAGES; p++) begin
            exp_q.push_back({1'b0, 8'hB0 | 8'(p)});
            exp_q.push_back(9'h000);
            exp_q.push_back(9'h010);
            for (int c = 0; c < LCD_W; c++) exp_q.push_back({1'b1, exp_data(p, c)});
        end
    endtask

    int         bit_n = 0, bytes_seen = 0, dc_bad = 0, done_n = 0, rd_en_n = 0;
    logic [7:0] sh = 8'h00;
    logic       dc_cap = 1'b0, sclk_prev = 1'b0;
    logic [8:0] e;

    always @(negedge clk) begin
        if (frame_done) done_n++;
        if (rd_en) rd_en_n++;
        if (!rst_n) begin
            bit_n     = 0;
            sclk_prev = 1'b0;
        end else begin
            if (lcd_sclk && !sclk_prev) begin
                sh = {sh[6:0], lcd_mosi};
                if (bit_n == 0) dc_cap = lcd_dc;
                else if (lcd_dc !== dc_cap) dc_bad++;
                bit_n++;
                if (bit_n == 8) begin
                    bit_n = 0;
                    bytes_seen++;
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL extra_byte: got %0h want none", {dc_cap, sh});
                    end else begin
                        e = exp_q.pop_front();
                        chk("byte", {dc_cap, sh}, e);
                    end
                end
            end
            sclk_prev = lcd_sclk;
        end
    end

    logic       done7 = 1'b0;
    logic [8:0] exp7[4];
    initial begin : drv7
        int         hi_run, lo_run, bits7, rd7;
        logic       prev7;
        logic [7:0] sh7;
        exp7[0] = 9'h0B0; exp7[1] = 9'h000; exp7[2] = 9'h010; exp7[3] = 9'h1FF;
        hi_run = 0; lo_run = 0; bits7 = 0; rd7 = 0; prev7 = 1'b0; sh7 = 8'h00;
        rst7_n = 1'b0; start7 = 1'b0;
        repeat (4) @(negedge clk);
        rst7_n = 1'b1;
        @(negedge clk);
        start7 = 1'b1;
        @(negedge clk);
        start7 = 1'b0;
        chk("d7_busy_after_start", busy7, 1);
        for (int k = 0; k < 2000 && bits7 < 32; k++) begin
            @(negedge clk);
            if (rd_en7) rd7++;
            if (sclk7) begin
                if (!prev7) begin
                    if (bits7 % 8 != 0) chk("d7_low_phase", lo_run, 7);
                    sh7 = {sh7[6:0], mosi7};
                    bits7++;
                    if (bits7 % 8 == 0) chk("d7_byte", {dc7, sh7}, exp7[bits7 / 8 - 1]);
                    hi_run = 0;
                end
                hi_run++;
            end else begin
                if (prev7) begin
                    chk("d7_high_phase", hi_run, 7);
                    lo_run = 0;
                end
                lo_run++;
            end
            prev7 = sclk7;
        end
        chk("d7_bits", bits7, 32);
        chk("d7_rd_en_cycles", rd7, 8);
        chk("d7_rd_addr_hold", rd_addr7, 14'h0380);
        chk("d7_cs_low", cs7_n, 0);
        chk("d7_no_frame_done", frame_done7, 0);
        rst7_n = 1'b0;
        done7  = 1'b1;
    end

    initial begin : main
        int     n, quiet, b0, b1, b2, d0, r0;
        longint start_cyc, f_cyc;
        rst_n = 1'b0; start = 1'b0; auto_refresh = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_cs_n", lcd_cs_n, 1);
        chk("rst_sclk", lcd_sclk, 0);
        chk("rst_rd_en", rd_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rd_addr", rd_addr, 0);
        chk("rst_frame_done", frame_done, 0);
        rst_n = 1'b1;

        quiet = 0;
        repeat (1000) begin
            @(negedge clk);
            if (!lcd_cs_n || lcd_sclk || rd_en || busy || frame_done) quiet++;
        end
        chk("idle_activity", quiet, 0);

        push_frame();
        b0 = bytes_seen; d0 = done_n; r0 = rd_en_n;
        start = 1'b1; start_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
        chk("start_cs_n", lcd_cs_n, 0);
        chk("start_busy", busy, 1);

        repeat (4000) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        auto_refresh = 1'b1;

        n = 0;
        while (!frame_done && n < 60000) begin
            @(negedge clk);
            n++;
        end
        chk("frame1_done_seen", frame_done, 1);
        f_cyc = cyc;
        b1 = bytes_seen;
        chk("frame1_cycles", f_cyc - start_cyc + 1, GOLDEN);
        chk("frame1_bytes", b1 - b0, BYTES_PER_FRAME);
        chk("frame1_queue_left", exp_q.size(), 0);
        chk("frame1_rd_en_cycles", rd_en_n - r0, LCD_W * LCD_H);
        chk("done_cs_n", lcd_cs_n, 1);
        chk("done_busy", busy, 0);

        push_frame();
        @(negedge clk);
        chk("frame_done_width", frame_done, 0);
        chk("auto_gap_cs_n", lcd_cs_n, 1);
        @(negedge clk);
        chk("auto_cs_n", lcd_cs_n, 0);
        chk("auto_busy", busy, 1);
        chk("frame_done_count", done_n - d0, 1);
        auto_refresh = 1'b0;

        n = 0;
        while (bytes_seen < b1 + 8 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("frame2_bytes_before_abort", bytes_seen - b1, 8);
        n = 0;
        while (!lcd_sclk && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_cs_n", lcd_cs_n, 1);
        chk("abort_sclk", lcd_sclk, 0);
        chk("abort_busy", busy, 0);
        chk("abort_mosi", lcd_mosi, 0);
        chk("abort_dc", lcd_dc, 0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        push_frame();
        b2 = bytes_seen;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (bytes_seen < b2 + 3 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("restart_cmd_bytes", bytes_seen - b2, 3);
        rst_n = 1'b0;
        exp_q.delete();

        n = 0;
        while (!done7 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("d7_finished", done7, 1);
        chk("dc_held_through_byte", dc_bad, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
